shift_pipe: RTL and testbench
=============================

# shift_pipe

Parametrised, pipelined barrel shifter for the ALU's shift path. It supersedes the single-cycle arithmetic-right shifter and performs logical-left, logical-right, arithmetic-right, rotate-left and rotate-right in one datapath. Shift levels are spread over a configurable number of register stages, and a valid/ready handshake with full-pipeline stall lets the execute stage absorb back-pressure. A tag travels alongside each operation so results can be matched to their issuing instruction.

## Interface
- XLEN, 32: data width; power of two, 8..64.
- SHW, $clog2(XLEN): shift-amount width (derived, not overridden).
- STAGES, 2: register stages, 1..SHW.
- TAG_W, 4: width of the sideband tag (≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block accepts operation this cycle.
- in_op  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101–111 reserved.
- in_a  in  XLEN  operand.
- in_shamt  in  SHW  shift amount, 0..XLEN-1.
- in_tag  in  TAG_W  sideband tag, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result this cycle.
- out_data  out  XLEN  shifted result.
- out_tag  out  TAG_W  tag of out_data.

## Operation
- Shifter levels are indexed i = 0..SHW-1. Level i shifts by 2^(SHW-1-i), so the largest shift is applied first, and it is enabled by in_shamt bit SHW-1-i.
- Level i belongs to stage floor(i*STAGES/SHW). Each stage ends in a register holding data, op, the remaining shamt bits, tag and a valid bit.
- Per-level fill bits:
  - SLL: zeros at the LSB end.
  - SRL: zeros at the MSB end.
  - SRA: copies of the original in_a[XLEN-1]. The sign is captured at input and carried with the op, not taken from the partial result.
  - ROL/ROR: the bits shifted out wrap around.
- Reserved op: out_data = in_a unchanged; the tag is still returned.
- shamt = 0: out_data = in_a for every op.
- Result is exact modular behaviour for XLEN bits. No flags are produced.

## Timing
- advance = !out_valid || out_ready. in_ready = advance, combinational; there is no path from in_valid to in_ready.
- Handshake fires when in_valid && in_ready. The operation is captured into stage 0 on that edge.
- Latency: out_valid is asserted exactly STAGES cycles after the accepting edge, provided advance stays high.
- Throughput: one operation per cycle while out_ready is held high.
- Stall: when advance = 0, every stage register holds, including bubbles. Bubbles are not compressed.
- out_data and out_tag are driven from the final register only. They stay stable while out_valid && !out_ready.
- Ordering: results leave strictly in acceptance order. No operation is dropped or duplicated.
- Reset (rst high at an edge), including mid-operation:
  - all stage valid bits, out_valid, out_data and out_tag go to 0 on that edge;
  - in-flight operations are discarded;
  - in_ready reads 1 in the cycle after reset.
- If in_valid is high while rst is asserted, the operation is not accepted.
- If a handshake on the output and a new acceptance occur in the same cycle, both take effect; the pipeline shifts by one.
- in_* inputs are don't-care when in_valid = 0. Bubble contents never appear with out_valid = 1.

## Test plan
- XLEN=32, STAGES=2, single ops with out_ready=1. Each result must appear with out_valid on the 2nd edge after acceptance:
  - SRA 0x80000000 by 31 → 0xFFFFFFFF.
  - SRL 0x80000000 by 31 → 0x00000001.
  - SLL 0x00000001 by 31 → 0x80000000.
- Rotates:
  - ROR 0x00000001 by 1 → 0x80000000.
  - ROL 0x80000001 by 4 → 0x00000018.
  - SRA 0x7FFFFFF0 by 4 → 0x07FFFFFF.
- shamt=0 for all five ops with in_a=0xDEADBEEF → 0xDEADBEEF. Reserved op 111, shamt 5 → 0xDEADBEEF, tag preserved.
- Back-pressure, STAGES=2: issue tags 1,2,3,4 back-to-back, hold out_ready=0 for 3 cycles from the first out_valid, then release.
  - in_ready must drop while stalled.
  - out_data must stay stable while stalled.
  - tags must emerge in order 1,2,3,4 with no loss or duplication.
- Reset mid-flight: accept 2 ops, assert rst on the next edge. Afterwards out_valid=0, out_data=0, out_tag=0 and in_ready=1, and neither discarded op ever appears.
- Sweep STAGES=1 and STAGES=5 (XLEN=32), plus XLEN=64 with STAGES=3:
  - random ops checked against a reference model;
  - latency must equal STAGES;
  - 1 result per cycle sustained with out_ready=1.

Source files
------------

// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with a tag sideband.
// Shift levels run largest-first and are spread over STAGES register stages.
//
// Handshake: an operation transfers on a rising edge where in_valid && in_ready.
// A result transfers on a rising edge where out_valid && out_ready. in_ready is
// !out_valid || out_ready and does not depend on in_valid. When it is low, every
// stage holds, bubbles included, so out_data/out_tag stay stable under back-pressure.
module shift_pipe #(
  parameter int XLEN   = 32,
  parameter int SHW    = $clog2(XLEN),
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  // Stage that owns shifter level lvl (level lvl shifts by 2^(SHW-1-lvl)).
  function automatic int stage_of(input int lvl);
    return (lvl * STAGES) / SHW;
  endfunction

  // One shifter level by a fixed distance k; the SRA fill is the captured sign.
  function automatic logic [XLEN-1:0] shift_level(input logic [XLEN-1:0] d,
                                                  input logic [2:0] op,
                                                  input logic sign,
                                                  input int k);
    logic [XLEN-1:0] r;
    r = d;
    case (op)
      OP_SLL:  r = d << k;
      OP_SRL:  r = d >> k;
      OP_SRA:  r = (d >> k) | (sign ? ~({XLEN{1'b1}} >> k) : '0);
      OP_ROL:  r = (d << k) | (d >> (XLEN - k));
      OP_ROR:  r = (d >> k) | (d << (XLEN - k));
      default: r = d;
    endcase
    return r;
  endfunction

  // Stage registers: data, op, shift amount, captured sign, tag, valid.
  logic [XLEN-1:0]  r_data  [STAGES];
  logic [2:0]       r_op    [STAGES];
  logic [SHW-1:0]   r_shamt [STAGES];
  logic             r_sign  [STAGES];
  logic [TAG_W-1:0] r_tag   [STAGES];
  logic             r_valid [STAGES];

  // Per-stage sources (inputs for stage 0, previous register otherwise) and results.
  logic [XLEN-1:0]  w_src_data  [STAGES];
  logic [2:0]       w_src_op    [STAGES];
  logic [SHW-1:0]   w_src_shamt [STAGES];
  logic             w_src_sign  [STAGES];
  logic [TAG_W-1:0] w_src_tag   [STAGES];
  logic             w_src_valid [STAGES];
  logic [XLEN-1:0]  w_res       [STAGES];
  logic             w_advance;
  logic             w_unused;

  assign w_advance = !r_valid[STAGES-1] || out_ready;
  assign in_ready  = w_advance;
  assign out_valid = r_valid[STAGES-1];
  assign out_data  = r_data[STAGES-1];
  assign out_tag   = r_tag[STAGES-1];

  // The final stage's control fields have no consumer downstream.
  assign w_unused = ^{r_op[STAGES-1], r_shamt[STAGES-1], r_sign[STAGES-1]};

  // Select what each stage works on: fresh operation for stage 0, else the prior register.
  always_comb begin
    w_src_data[0]  = in_a;
    w_src_op[0]    = in_op;
    w_src_shamt[0] = in_shamt;
    w_src_sign[0]  = in_a[XLEN-1];
    w_src_tag[0]   = in_tag;
    w_src_valid[0] = in_valid;
    for (int s = 1; s < STAGES; s++) begin
      w_src_data[s]  = r_data[s-1];
      w_src_op[s]    = r_op[s-1];
      w_src_shamt[s] = r_shamt[s-1];
      w_src_sign[s]  = r_sign[s-1];
      w_src_tag[s]   = r_tag[s-1];
      w_src_valid[s] = r_valid[s-1];
    end
  end

  // Apply the shifter levels owned by each stage, largest distance first.
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      w_res[s] = w_src_data[s];
      for (int i = 0; i < SHW; i++) begin
        if (stage_of(i) == s && w_src_shamt[s][SHW-1-i]) begin
          w_res[s] = shift_level(w_res[s], w_src_op[s], w_src_sign[s], 1 << (SHW - 1 - i));
        end
      end
    end
  end

  // Advance the whole pipeline together; clear everything on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        r_valid[s] <= 1'b0;
        r_data[s]  <= '0;
        r_op[s]    <= '0;
        r_shamt[s] <= '0;
        r_sign[s]  <= 1'b0;
        r_tag[s]   <= '0;
      end
    end else if (w_advance) begin
      for (int s = 0; s < STAGES; s++) begin
        r_valid[s] <= w_src_valid[s];
        r_data[s]  <= w_res[s];
        r_op[s]    <= w_src_op[s];
        r_shamt[s] <= w_src_shamt[s];
        r_sign[s]  <= w_src_sign[s];
        r_tag[s]   <= w_src_tag[s];
      end
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: four shift_pipe instances (32/2, 32/1, 32/5, 64/3) share one
// stimulus stream; each has its own expected queue fed from its own handshakes.
module tb_shift_pipe;

  localparam int N     = 4;
  localparam int TAG_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [2:0]       in_op;
  logic [63:0]      in_a;
  logic [5:0]       in_shamt;
  logic [TAG_W-1:0] in_tag;
  logic             out_ready;
  logic             lat_chk;
  logic             log_en;
  int               cyc;
  int               checks;
  int               failures;
  logic [TAG_W-1:0] got_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference result: whole shift done at once on an xl-bit value.
  function automatic logic [63:0] model(input int xl, input logic [2:0] op,
                                        input logic [63:0] a_in, input int s);
    logic [63:0] m, a, r;
    m = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << xl) - 64'd1);
    a = a_in & m;
    case (op)
      3'd0: r = a << s;
      3'd1: r = a >> s;
      3'd2: begin
        r = a >> s;
        if (a[xl-1]) r = r | (m & ~(m >> s));
      end
      3'd3: r = (s == 0) ? a : ((a << s) | (a >> (xl - s)));
      3'd4: r = (s == 0) ? a : ((a >> s) | (a << (xl - s)));
      default: r = a;
    endcase
    return r & m;
  endfunction

  // ---------------- DUT instances + per-instance scoreboard ----------------
  for (genvar k = 0; k < N; k++) begin : g
    localparam int W  = (k == 3) ? 64 : 32;
    localparam int S  = (k == 0) ? 2 : (k == 1) ? 1 : (k == 2) ? 5 : 3;
    localparam int SW = $clog2(W);

    logic             in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;
    logic [W-1:0]     exp_q[$];
    logic [TAG_W-1:0] tag_q[$];
    int               acc_q[$];
    logic [63:0]      m64;

    shift_pipe #(.XLEN(W), .STAGES(S), .TAG_W(TAG_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_op    (in_op),
      .in_a     (in_a[W-1:0]),
      .in_shamt (in_shamt[SW-1:0]),
      .in_tag   (in_tag),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_tag  (out_tag)
    );

    always @(negedge clk) begin
      if (rst) begin
        exp_q.delete();
        tag_q.delete();
        acc_q.delete();
      end else begin
        if (exp_q.size() == 0) begin
          chk($sformatf("d%0d_unexpected_valid", k), 64'(out_valid), 64'd0);
        end else begin
          if (lat_chk && cyc >= acc_q[0] + S)
            chk($sformatf("d%0d_valid_due", k), 64'(out_valid), 64'd1);
          if (out_valid) begin
            chk($sformatf("d%0d_data", k), 64'(out_data), 64'(exp_q[0]));
            chk($sformatf("d%0d_tag", k), 64'(out_tag), 64'(tag_q[0]));
            if (lat_chk) chk($sformatf("d%0d_latency", k), 64'(cyc - acc_q[0]), 64'(S));
          end
        end
        if (lat_chk && out_ready) chk($sformatf("d%0d_in_ready", k), 64'(in_ready), 64'd1);
        if (out_valid && out_ready && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          void'(tag_q.pop_front());
          void'(acc_q.pop_front());
        end
        if (in_valid && in_ready) begin
          m64 = model(W, in_op, in_a, int'(in_shamt[SW-1:0]));
          exp_q.push_back(m64[W-1:0]);
          tag_q.push_back(in_tag);
          acc_q.push_back(cyc);
        end
      end
    end
  end

  // Order log of results taken from the 32/2 instance.
  always @(negedge clk) begin
    if (log_en && g[0].out_valid && out_ready) got_q.push_back(g[0].out_tag);
  end

  // ---------------- driver tasks (called at posedge + #1) ----------------
  task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [5:0] sh,
                      input logic [TAG_W-1:0] tag);
    int n;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_shamt = sh;
    in_tag   = tag;
    n = 0;
    @(negedge clk);
    while (!g[0].in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", 64'(g[0].in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_one(input logic [2:0] op, input logic [63:0] a, input logic [5:0] sh,
                         input logic [TAG_W-1:0] tag, input logic [31:0] exp);
    int n;
    logic seen;
    send(op, a, sh, tag);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = g[0].out_valid;
    end
    chk("dir_seen", 64'(seen), 64'd1);
    chk("dir_edges", 64'(n), 64'd2);
    chk("dir_data", 64'(g[0].out_data), 64'(exp));
    chk("dir_tag", 64'(g[0].out_tag), 64'(tag));
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_shamt = '0; in_tag = '0;
    out_ready = 1'b1; lat_chk = 1'b0; log_en = 1'b0;
    cyc = 0; checks = 0; failures = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 64'(g[0].out_valid), 64'd0);
    chk("reset_out_data", 64'(g[0].out_data), 64'd0);
    chk("reset_out_tag", 64'(g[0].out_tag), 64'd0);
    chk("reset_in_ready", 64'(g[0].in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed single operations with literal results.
    lat_chk = 1'b1;
    run_one(3'd2, 64'h8000_0000, 6'd31, 4'd1, 32'hFFFF_FFFF);
    run_one(3'd1, 64'h8000_0000, 6'd31, 4'd2, 32'h0000_0001);
    run_one(3'd0, 64'h0000_0001, 6'd31, 4'd3, 32'h8000_0000);
    run_one(3'd4, 64'h0000_0001, 6'd1,  4'd4, 32'h8000_0000);
    run_one(3'd3, 64'h8000_0001, 6'd4,  4'd5, 32'h0000_0018);
    run_one(3'd2, 64'h7FFF_FFF0, 6'd4,  4'd6, 32'h07FF_FFFF);
    for (int op = 0; op < 5; op++)
      run_one(3'(op), 64'hDEAD_BEEF, 6'd0, 4'(op + 7), 32'hDEAD_BEEF);
    run_one(3'd7, 64'hDEAD_BEEF, 6'd5, 4'd12, 32'hDEAD_BEEF);
    repeat (8) @(posedge clk);
    #1;

    // Back-pressure: tags 1..4 back-to-back, 3-cycle stall from first out_valid.
    lat_chk = 1'b0;
    got_q.delete();
    log_en = 1'b1;
    fork
      begin
        for (int t = 1; t <= 4; t++) send(3'd0, 64'h1, 6'(t), 4'(t));
      end
      begin : b_stall
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while (!g[0].out_valid && n < 20) begin
          @(posedge clk);
          #1;
          n++;
        end
        chk("bp_first_valid", 64'(g[0].out_valid), 64'd1);
        out_ready = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
          chk("bp_in_ready_low", 64'(g[0].in_ready), 64'd0);
          chk("bp_valid_held", 64'(g[0].out_valid), 64'd1);
          chk("bp_data_held", 64'(g[0].out_data), 64'h2);
          chk("bp_tag_held", 64'(g[0].out_tag), 64'd1);
          @(posedge clk);
          #2;
        end
        out_ready = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    log_en = 1'b0;
    chk("bp_count", 64'(got_q.size()), 64'd4);
    if (got_q.size() == 4) begin
      chk("bp_order0", 64'(got_q[0]), 64'd1);
      chk("bp_order1", 64'(got_q[1]), 64'd2);
      chk("bp_order2", 64'(got_q[2]), 64'd3);
      chk("bp_order3", 64'(got_q[3]), 64'd4);
    end

    // Reset mid-flight: two ops held in the pipe, then reset with an op offered.
    got_q.delete();
    log_en = 1'b1;
    out_ready = 1'b0;
    send(3'd1, 64'hF0, 6'd4, 4'd9);
    send(3'd1, 64'hF0, 6'd4, 4'd10);
    rst = 1'b1; in_valid = 1'b1; in_op = 3'd0; in_a = 64'h5; in_shamt = 6'd1; in_tag = 4'd11;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", 64'(g[0].out_valid), 64'd0);
    chk("rst_out_data", 64'(g[0].out_data), 64'd0);
    chk("rst_out_tag", 64'(g[0].out_tag), 64'd0);
    chk("rst_in_ready", 64'(g[0].in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    log_en = 1'b0;
    chk("rst_nothing_emerged", 64'(got_q.size()), 64'd0);

    // Sustained random ops, one per cycle, latency and throughput checked.
    lat_chk = 1'b1;
    for (int j = 0; j < 150; j++) begin
      in_valid = 1'b1;
      in_op    = 3'($urandom_range(0, 7));
      in_a     = {$urandom, $urandom};
      in_shamt = 6'($urandom_range(0, 63));
      in_tag   = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Random valid and random back-pressure.
    lat_chk = 1'b0;
    for (int j = 0; j < 200; j++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_op     = 3'($urandom_range(0, 7));
      in_a      = {$urandom, $urandom};
      in_shamt  = 6'($urandom_range(0, 63));
      in_tag    = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;

    chk("drain_d0", 64'(g[0].exp_q.size()), 64'd0);
    chk("drain_d1", 64'(g[1].exp_q.size()), 64'd0);
    chk("drain_d2", 64'(g[2].exp_q.size()), 64'd0);
    chk("drain_d3", 64'(g[3].exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
